// File: rtl/cbm2_rom_pkg.sv
// Shared definitions for the CBM-II ROM loader: parser states, header field
// widths, record length limit and well-known ROM ids.
package cbm2_rom_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ID,
      LLO,
      LHI,
      DATA,
      CHK,
      SKIP
   } parse_state_t;

   localparam int MAX_LEN  = 16384;
   localparam int ID_W     = 6;
   localparam int ADDR_W   = $clog2(MAX_LEN);
   localparam int LEN_W    = ADDR_W;
   localparam int FLAG_IDS = 16;

   localparam logic [ID_W-1:0] CHAR_BL = 6'd12;
   localparam logic [ID_W-1:0] CHAR_BH = 6'd13;

   // Header bytes (ID and LEN_HI) must keep their two top bits clear.
   function automatic logic hdr_ok(input logic [7:0] b);
      return b[7:6] == 2'b00;
   endfunction

   function automatic logic has_flag(input logic [ID_W-1:0] id);
      return id < ID_W'(FLAG_IDS);
   endfunction

endpackage

// File: rtl/rom_loader.sv
// Parses the HPS ioctl download stream into ROM records and writes each
// payload byte into the selected ROM, tracking per-record checksum status.
module rom_loader
   import cbm2_rom_pkg::*;
#(
   parameter logic [7:0] ROM_INDEX = 8'd0
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_dout,
   output logic [5:0]  rom_id,
   output logic [13:0] rom_addr,
   output logic        rom_wr,
   output logic [7:0]  rom_data,
   output logic [15:0] loaded,
   output logic        load_err,
   output logic        busy
);

   parse_state_t state, state_next;

   logic        win, win_d, win_rise;
   logic [7:0]  len_lo, len_lo_next;
   logic [13:0] len_m1, len_m1_next;
   logic [13:0] cnt, cnt_next;
   logic [7:0]  sum, sum_next;
   logic [5:0]  id_next;
   logic [13:0] addr_next;
   logic [7:0]  data_next;
   logic        wr_next;
   logic [15:0] loaded_next;
   logic        err_next;

   assign win      = ioctl_download && (ioctl_index == ROM_INDEX);
   assign win_rise = win && !win_d;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A falling window wins over any strobe in the same cycle; bytes are
   // only consumed once the rising edge has moved the parser out of IDLE.
   always_comb begin
      state_next  = state;
      id_next     = rom_id;
      len_lo_next = len_lo;
      len_m1_next = len_m1;
      cnt_next    = cnt;
      sum_next    = sum;
      loaded_next = loaded;
      err_next    = load_err;
      wr_next     = 1'b0;
      addr_next   = rom_addr;
      data_next   = rom_data;

      if (!win) begin
         if (state inside {LLO, LHI, DATA, CHK}) begin
            err_next = 1'b1;
         end
         state_next = IDLE;
      end else if (state == IDLE) begin
         if (win_rise) begin
            state_next = ID;
            err_next   = 1'b0;
            cnt_next   = '0;
            sum_next   = '0;
         end
      end else if (ioctl_wr) begin
         case (state)
            ID: begin
               if (hdr_ok(ioctl_dout)) begin
                  id_next  = ioctl_dout[5:0];
                  cnt_next = '0;
                  sum_next = '0;
                  if (has_flag(ioctl_dout[5:0])) begin
                     loaded_next[ioctl_dout[3:0]] = 1'b0;
                  end
                  state_next = LLO;
               end else begin
                  err_next   = 1'b1;
                  state_next = SKIP;
               end
            end
            LLO: begin
               len_lo_next = ioctl_dout;
               state_next  = LHI;
            end
            LHI: begin
               if (hdr_ok(ioctl_dout)) begin
                  len_m1_next = {ioctl_dout[5:0], len_lo};
                  state_next  = DATA;
               end else begin
                  err_next   = 1'b1;
                  state_next = SKIP;
               end
            end
            DATA: begin
               wr_next   = 1'b1;
               addr_next = cnt;
               data_next = ioctl_dout;
               sum_next  = sum + ioctl_dout;
               cnt_next  = cnt + 14'd1;
               if (cnt == len_m1) begin
                  state_next = CHK;
               end
            end
            CHK: begin
               if (ioctl_dout == sum) begin
                  if (has_flag(rom_id)) begin
                     loaded_next[rom_id[3:0]] = 1'b1;
                  end
               end else begin
                  err_next = 1'b1;
               end
               state_next = ID;
            end
            default: begin
            end
         endcase
      end
   end

   // busy is registered from the next state so it tracks state exactly.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         win_d    <= 1'b0;
         len_lo   <= '0;
         len_m1   <= '0;
         cnt      <= '0;
         sum      <= '0;
         rom_id   <= '0;
         rom_addr <= '0;
         rom_wr   <= 1'b0;
         rom_data <= '0;
         loaded   <= '0;
         load_err <= 1'b0;
         busy     <= 1'b0;
      end else begin
         win_d    <= win;
         len_lo   <= len_lo_next;
         len_m1   <= len_m1_next;
         cnt      <= cnt_next;
         sum      <= sum_next;
         rom_id   <= id_next;
         rom_addr <= addr_next;
         rom_wr   <= wr_next;
         rom_data <= data_next;
         loaded   <= loaded_next;
         load_err <= err_next;
         busy     <= (state_next != IDLE);
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: a record-level stream model predicts ROM
// writes and status flags, and a per-cycle monitor checks every rom_wr.
module tb_rom_loader;
   import cbm2_rom_pkg::*;

   localparam logic [7:0] LOADER_INDEX = 8'h03;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'h00;
   logic        ioctl_wr = 1'b0;
   logic [7:0]  ioctl_dout = 8'h00;
   logic [5:0]  rom_id;
   logic [13:0] rom_addr;
   logic        rom_wr;
   logic [7:0]  rom_data;
   logic [15:0] loaded;
   logic        load_err;
   logic        busy;

   typedef struct packed {
      logic [5:0]  id;
      logic [13:0] addr;
      logic [7:0]  data;
   } exp_wr_t;

   exp_wr_t     exp_q[$];
   logic [7:0]  stream_q[$];
   logic [15:0] exp_loaded = '0;
   logic        exp_err = 1'b0;

   int checks = 0;
   int errors = 0;
   int wr_total = 0;
   int run_len = 0;
   int wr_mark;
   logic prev_wr = 1'b0;

   rom_loader #(.ROM_INDEX(LOADER_INDEX)) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_dout     (ioctl_dout),
      .rom_id         (rom_id),
      .rom_addr       (rom_addr),
      .rom_wr         (rom_wr),
      .rom_data       (rom_data),
      .loaded         (loaded),
      .load_err       (load_err),
      .busy           (busy)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Walk the whole window at record granularity and predict its effects.
   task automatic model_window();
      int n = stream_q.size();
      int pos = 0;
      int len;
      logic [7:0] sum;
      logic [5:0] id;
      logic trunc;
      exp_err = 1'b0;
      while (pos < n) begin
         if (stream_q[pos][7:6] != 2'b00) begin exp_err = 1'b1; break; end
         id = stream_q[pos][5:0];
         if (id < 6'd16) exp_loaded[id[3:0]] = 1'b0;
         if (pos + 2 >= n) begin exp_err = 1'b1; break; end
         if (stream_q[pos+2][7:6] != 2'b00) begin exp_err = 1'b1; break; end
         len = int'({stream_q[pos+2][5:0], stream_q[pos+1]}) + 1;
         sum = 8'h00;
         trunc = 1'b0;
         for (int k = 0; k < len; k++) begin
            if (pos + 3 + k >= n) begin trunc = 1'b1; break; end
            exp_q.push_back('{id: id, addr: 14'(k), data: stream_q[pos+3+k]});
            sum = sum + stream_q[pos+3+k];
         end
         if (trunc || (pos + 3 + len >= n)) begin exp_err = 1'b1; break; end
         if (stream_q[pos+3+len] == sum) begin
            if (id < 6'd16) exp_loaded[id[3:0]] = 1'b1;
         end else begin
            exp_err = 1'b1;
         end
         pos = pos + len + 4;
      end
   endtask

   task automatic end_window();
      ioctl_download = 1'b0;
      @(posedge clk_sys); #1;
   endtask

   task automatic applyStimulus(input int gap, input bit drop);
      model_window();
      @(posedge clk_sys); #1;
      ioctl_index = LOADER_INDEX;
      ioctl_download = 1'b1;
      @(posedge clk_sys); #1;
      foreach (stream_q[i]) begin
         ioctl_wr = 1'b1;
         ioctl_dout = stream_q[i];
         @(posedge clk_sys); #1;
         if (gap > 0) begin
            ioctl_wr = 1'b0;
            repeat (gap) begin @(posedge clk_sys); #1; end
         end
      end
      ioctl_wr = 1'b0;
      repeat (2) begin @(posedge clk_sys); #1; end
      if (drop) end_window();
   endtask

   task automatic check_status(input string tag);
      checkOutput({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
      checkOutput({tag, "_loaded_model"}, 32'(loaded), 32'(exp_loaded));
      checkOutput({tag, "_load_err_model"}, 32'(load_err), 32'(exp_err));
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_rom_id"}, 32'(rom_id), 32'd0);
      checkOutput({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
      checkOutput({tag, "_rom_wr"}, 32'(rom_wr), 32'd0);
      checkOutput({tag, "_rom_data"}, 32'(rom_data), 32'd0);
      checkOutput({tag, "_loaded"}, 32'(loaded), 32'd0);
      checkOutput({tag, "_load_err"}, 32'(load_err), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Every rom_wr must match the next write the model predicted.
   always @(negedge clk_sys) begin
      if (reset_n) begin
         if (rom_wr) begin
            wr_total++;
            run_len = prev_wr ? run_len + 1 : 1;
            if (exp_q.size() == 0) begin
               checkOutput("rom_wr_unexpected", 32'(rom_wr), 32'd0);
            end else begin
               exp_wr_t e;
               e = exp_q.pop_front();
               checkOutput("rom_write", 32'({rom_id, rom_addr, rom_data}), 32'(e));
            end
         end
         prev_wr = rom_wr;
      end else begin
         prev_wr = 1'b0;
      end
   end

   initial begin
      repeat (200000) @(posedge clk_sys);
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] b;
      logic [7:0] s;

      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check_all_zero("reset");
      #1 reset_n = 1'b1;

      // Good record for the low character ROM.
      stream_q = '{CHAR_BL, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      wr_mark = wr_total;
      applyStimulus(1, 1'b1);
      check_status("good");
      checkOutput("good_writes", 32'(wr_total - wr_mark), 32'd4);
      checkOutput("good_loaded12", 32'(loaded[12]), 32'd1);
      checkOutput("good_err", 32'(load_err), 32'd0);
      checkOutput("good_hold_addr", 32'(rom_addr), 32'd3);
      checkOutput("good_hold_id", 32'(rom_id), 32'd12);

      // Same record, wrong checksum.
      stream_q = '{CHAR_BL, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
      wr_mark = wr_total;
      applyStimulus(0, 1'b1);
      check_status("badchk");
      checkOutput("badchk_writes", 32'(wr_total - wr_mark), 32'd4);
      checkOutput("badchk_loaded12", 32'(loaded[12]), 32'd0);
      checkOutput("badchk_err", 32'(load_err), 32'd1);

      // Two 8192-byte records streamed with a strobe every cycle.
      stream_q.delete();
      for (int r = 0; r < 2; r++) begin
         stream_q.push_back(r == 0 ? 8'(CHAR_BL) : 8'(CHAR_BH));
         stream_q.push_back(8'hFF);
         stream_q.push_back(8'h1F);
         s = 8'h00;
         for (int i = 0; i < 8192; i++) begin
            b = 8'((i * 7 + r * 3 + 1) & 255);
            stream_q.push_back(b);
            s = s + b;
         end
         stream_q.push_back(s);
      end
      wr_mark = wr_total;
      applyStimulus(0, 1'b1);
      check_status("big");
      checkOutput("big_writes", 32'(wr_total - wr_mark), 32'd16384);
      checkOutput("big_run_len", 32'(run_len), 32'd8192);
      checkOutput("big_last_addr", 32'(rom_addr), 32'd8191);
      checkOutput("big_last_id", 32'(rom_id), 32'd13);
      checkOutput("big_loaded", 32'(loaded[13:12]), 32'd3);
      checkOutput("big_err", 32'(load_err), 32'd0);

      // Illegal ID byte: everything after it is ignored until the window ends.
      stream_q = '{8'h4C, 8'h0C, 8'h03, 8'h00, 8'h01, 8'h02};
      wr_mark = wr_total;
      applyStimulus(0, 1'b0);
      checkOutput("badid_err", 32'(load_err), 32'd1);
      checkOutput("badid_busy_open", 32'(busy), 32'd1);
      checkOutput("badid_writes", 32'(wr_total - wr_mark), 32'd0);
      end_window();
      checkOutput("badid_busy_closed", 32'(busy), 32'd0);
      check_status("badid");

      // Window closes after two of four payload bytes.
      stream_q = '{CHAR_BL, 8'h03, 8'h00, 8'h11, 8'h22};
      wr_mark = wr_total;
      applyStimulus(1, 1'b1);
      checkOutput("trunc_busy", 32'(busy), 32'd0);
      checkOutput("trunc_writes", 32'(wr_total - wr_mark), 32'd2);
      checkOutput("trunc_err", 32'(load_err), 32'd1);
      check_status("trunc");

      // Reset in the middle of a payload.
      stream_q = '{CHAR_BH, 8'h03, 8'h00, 8'hAA, 8'hBB};
      wr_mark = wr_total;
      applyStimulus(0, 1'b0);
      checkOutput("rst_pre_writes", 32'(wr_total - wr_mark), 32'd2);
      reset_n = 1'b0;
      exp_loaded = '0;
      exp_err = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ioctl_wr = 1'b1;
         ioctl_dout = 8'hC0 + 8'(i);
         @(posedge clk_sys); #1;
      end
      ioctl_wr = 1'b0;
      @(negedge clk_sys);
      check_all_zero("in_reset");
      #1 ioctl_download = 1'b0;
      @(posedge clk_sys); #1;
      reset_n = 1'b1;

      // Strobes for a different download index are not ours.
      wr_mark = wr_total;
      ioctl_index = 8'h00;
      ioctl_download = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ioctl_wr = 1'b1;
         ioctl_dout = 8'(i * 3);
         @(posedge clk_sys); #1;
      end
      ioctl_wr = 1'b0;
      repeat (2) begin @(posedge clk_sys); #1; end
      check_all_zero("other_index");
      checkOutput("other_index_writes", 32'(wr_total - wr_mark), 32'd0);
      ioctl_download = 1'b0;
      repeat (2) @(posedge clk_sys);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 The module SHALL have parameter ROM_INDEX, default 8'd0, which is the ioctl_index value that selects this loader.
REQ-002 The module SHALL have port clk_sys, input, 1 bit: the system clock. All logic is on the rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port ioctl_download, input, 1 bit: the HPS download window is active.
REQ-005 The module SHALL have port ioctl_index, input, 8 bits: the download file index.
REQ-006 The module SHALL have port ioctl_wr, input, 1 bit: a one-cycle byte strobe.
REQ-007 The module SHALL have port ioctl_dout, input, 8 bits: the stream byte, valid while ioctl_wr is high.
REQ-008 The module SHALL have port rom_id, output, 6 bits: the target ROM id of the current record.
REQ-009 The module SHALL have port rom_addr, output, 14 bits: the byte offset within the target ROM.
REQ-010 The module SHALL have port rom_wr, output, 1 bit: a one-cycle write strobe to the ROM memories.
REQ-011 The module SHALL have port rom_data, output, 8 bits: the write data.
REQ-012 The module SHALL have port loaded, output, 16 bits: per-id flags showing that a record passed its checksum (ids 0-15).
REQ-013 The module SHALL have port load_err, output, 1 bit: a sticky flag for a stream error in the current or last window.
REQ-014 The module SHALL have port busy, output, 1 bit: the parser is not IDLE.

Function
REQ-015 The window SHALL be active only while ioctl_download=1 and ioctl_index==ROM_INDEX; ioctl_wr outside the active window SHALL be ignored.
REQ-016 The stream SHALL be a sequence of records of the form ID byte, LEN_LO, LEN_HI, payload bytes, CHK byte.
REQ-017 Record length SHALL be {LEN_HI[5:0],LEN_LO}+1, giving a range of 1..16384 bytes.
REQ-018 The parser SHALL use the states IDLE, ID, LLO, LHI, DATA, CHK and SKIP, and each accepted byte (ioctl_wr=1) SHALL advance it at most one state.
REQ-019 On the rising edge of the active window, the parser SHALL go from IDLE to ID, clear load_err, and zero the address counter and checksum.
REQ-020 In state ID, if byte[7:6]==0 the parser SHALL latch rom_id=byte[5:0], clear loaded[id] when id<16, and go to LLO; otherwise it SHALL set load_err and go to SKIP.
REQ-021 In state LLO, the parser SHALL latch the low length byte and go to LHI.
REQ-022 In state LHI, if byte[7:6]==0 the parser SHALL latch the length and go to DATA; otherwise it SHALL set load_err and go to SKIP.
REQ-023 In state DATA, for payload byte n, rom_wr SHALL be high for exactly the one cycle after the ioctl_wr cycle, with rom_addr=n and rom_data=byte (write latency 1 cycle).
REQ-024 In state DATA, the checksum SHALL accumulate as an 8-bit sum modulo 256, and the parser SHALL go to CHK after byte n=length-1.
REQ-025 The parser SHALL accept back-to-back ioctl_wr in consecutive cycles and produce rom_wr on consecutive cycles with no dropped bytes.
REQ-026 rom_id, rom_addr and rom_data SHALL hold their values between writes.
REQ-027 In state CHK, on a match the parser SHALL set loaded[id] when id<16; on a mismatch it SHALL set load_err. In both cases it SHALL then go to ID for the next record.
REQ-028 Records with id>=16 SHALL still be written to the ROMs but SHALL not affect loaded.
REQ-029 In state SKIP, all bytes SHALL be ignored with no rom_wr until the window ends.
REQ-030 When the window falls, the parser SHALL go to IDLE. If it was in LLO, LHI, DATA or CHK (a truncated record), it SHALL set load_err.
REQ-031 An ioctl_wr arriving in the same cycle as the window falling SHALL be ignored.
REQ-032 busy SHALL equal (state != IDLE) and be registered.

Reset
REQ-033 While reset_n=0, the state SHALL be IDLE and all outputs SHALL be 0 (rom_id, rom_addr, rom_wr, rom_data, loaded, load_err, busy).
REQ-034 A reset asserted mid-record SHALL abort the record with no further rom_wr; partial ROM contents SHALL be left as written.

Structure
REQ-035 The shared package cbm2_rom_pkg SHALL hold the parser state enum, the header field widths, the maximum length (16384), and the ROM id constants (CHAR_BL=12, CHAR_BH=13).
REQ-036 No sub-module is needed; the block SHALL be a single FSM with its counter and checksum datapath.

Verification
REQ-037 Bench scenario: single record id=12, len=4, payload 01 02 03 04, CHK=0A -> four rom_wr pulses at addr 0..3 with id 12, loaded[12]=1, load_err=0.
REQ-038 Bench scenario: same record with CHK=0B -> four writes occur, loaded[12]=0, load_err=1.
REQ-039 Bench scenario: two records (id 12, then id 13, len 8192 each) with ioctl_wr every cycle -> 16384 writes with no gaps, last addr 8191 for id 13, loaded[13:12]=2'b11.
REQ-040 Bench scenario: ID byte 0x4C -> load_err=1, no rom_wr for the rest of the window, busy=1 until the window falls.
REQ-041 Bench scenario: window drops after 2 of 4 payload bytes -> 2 writes, load_err=1, busy=0 the next cycle.
REQ-042 Bench scenario: reset_n pulsed low during DATA, and ioctl_index!=ROM_INDEX with strobes -> no rom_wr and all outputs 0.
